// File: rtl/core_pkg.sv
// Shared constants, formatter state type and nibble-to-ASCII helper for the
// stdout formatter.
package core_pkg;

    localparam logic [7:0] ASCII_NL = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_UA = 8'h41;
    localparam logic [7:0] ASCII_LA = 8'h61;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        NL    = 2'd2
    } fmt_state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib, input logic upper);
        logic [7:0] base;
        base = upper ? ASCII_UA : ASCII_LA;
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return base + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/stdio.sv
// Valid/ready word stream carrying the core's stdout output.
interface stdio;
    logic [15:0] data;
    logic        val;
    logic        rdy;

    modport in  (input data, input val, output rdy);
    modport out (output data, output val, input rdy);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head; full and empty are told apart
// by an extra wrap bit on each pointer.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       data_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Guarded with registered flags only, so a same-cycle pop never frees a full FIFO.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/core_stdout_fmt.sv
// Buffers 16-bit stdout words and emits each as four hex ASCII digits
// (MSB first) followed by a newline on a valid/ready byte port.
//
// state | meaning
// IDLE  | no word in flight, tx_val_o low
// DIGIT | presenting hex digit cnt_q of the word in sr_q
// NL    | presenting the trailing newline
module core_stdout_fmt
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int UPPER = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    stdio.in                       word_intf,
    output logic                   tx_val_o,
    output logic [7:0]             tx_byte_o,
    input  logic                   tx_rdy_i,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam logic UP = (UPPER != 0);

    fmt_state_e  state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        tx_val_q, tx_val_d;
    logic [7:0]  tx_byte_q, tx_byte_d;

    logic [15:0] head;
    logic        full, empty, push, pop, xfer;

    assign word_intf.rdy = !full;
    assign push          = word_intf.val && !full;
    assign xfer          = tx_val_q && tx_rdy_i;
    assign tx_val_o      = tx_val_q;
    assign tx_byte_o     = tx_byte_q;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (word_intf.data),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level_o)
    );

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        tx_val_d  = tx_val_q;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    sr_d      = head;
                    cnt_d     = 2'd0;
                    tx_val_d  = 1'b1;
                    tx_byte_d = hex_ascii(head[15:12], UP);
                    state_d   = DIGIT;
                end
            end
            DIGIT: begin
                if (xfer) begin
                    if (cnt_q == 2'd3) begin
                        tx_byte_d = ASCII_NL;
                        state_d   = NL;
                    end else begin
                        sr_d      = {sr_q[11:0], 4'h0};
                        cnt_d     = cnt_q + 2'd1;
                        tx_byte_d = hex_ascii(sr_q[11:8], UP);
                    end
                end
            end
            NL: begin
                // Load the next word on the newline's transfer edge so words run back to back.
                if (xfer) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        sr_d      = head;
                        cnt_d     = 2'd0;
                        tx_byte_d = hex_ascii(head[15:12], UP);
                        state_d   = DIGIT;
                    end else begin
                        tx_val_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                tx_val_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            tx_val_q  <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            tx_val_q  <= tx_val_d;
            tx_byte_q <= tx_byte_d;
        end
    end

endmodule

// File: tb/tb_core_stdout_fmt.sv
// Directed bench for core_stdout_fmt: table of single-word vectors on an
// upper-case and a lower-case instance, plus multi-cycle corner sequences.
module tb_core_stdout_fmt;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rdy_u, rdy_l;
    logic       tv_u, tv_l;
    logic [7:0] tb_u, tb_l;
    logic [2:0] lv_u, lv_l;

    stdio wi_u ();
    stdio wi_l ();

    core_stdout_fmt #(.DEPTH(4), .UPPER(1)) dut_u (
        .clk_i     (clk),
        .rst_i     (rst),
        .word_intf (wi_u),
        .tx_val_o  (tv_u),
        .tx_byte_o (tb_u),
        .tx_rdy_i  (rdy_u),
        .level_o   (lv_u)
    );

    core_stdout_fmt #(.DEPTH(4), .UPPER(0)) dut_l (
        .clk_i     (clk),
        .rst_i     (rst),
        .word_intf (wi_l),
        .tx_val_o  (tv_l),
        .tx_byte_o (tb_l),
        .tx_rdy_i  (rdy_l),
        .level_o   (lv_l)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [7:0] got_u[$], got_l[$];
    int         cyc_u[$], cyc_l[$];
    int         cyc = 0;
    logic       hold_pend = 1'b0;
    logic [7:0] held_byte = 8'h00;

    // Transfer capture, plus the "held stable under backpressure" check.
    always @(posedge clk) begin
        if (hold_pend && tv_u) begin
            check("hold_stable", tb_u, held_byte);
        end
        hold_pend = tv_u && !rdy_u;
        held_byte = tb_u;
        if (tv_u && rdy_u) begin
            got_u.push_back(tb_u);
            cyc_u.push_back(cyc);
        end
        if (tv_l && rdy_l) begin
            got_l.push_back(tb_l);
            cyc_l.push_back(cyc);
        end
        cyc++;
    end

    function automatic int qsize(input int sel);
        return (sel == 0) ? got_u.size() : got_l.size();
    endfunction

    function automatic logic [127:0] pack(input int sel, input int start, input int n);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            r = (r << 8) | ((sel == 0) ? got_u[start+k] : got_l[start+k]);
        end
        return r;
    endfunction

    function automatic logic [39:0] exp_word(input logic [15:0] w, input bit upper);
        logic [39:0] r;
        logic [3:0]  n;
        r = '0;
        for (int k = 3; k >= 0; k--) begin
            n = w[k*4 +: 4];
            r = (r << 8) | ((n < 10) ? (8'h30 + n) : ((upper ? 8'h41 : 8'h61) + n - 8'd10));
        end
        return (r << 8) | 40'h0A;
    endfunction

    task automatic clr();
        got_u.delete(); got_l.delete(); cyc_u.delete(); cyc_l.delete();
    endtask

    // Called and returns at a negedge; holds val until the word is accepted.
    task automatic push(input int sel, input logic [15:0] w);
        logic acc;
        acc = 1'b0;
        if (sel == 0) begin wi_u.data = w; wi_u.val = 1'b1; end
        else          begin wi_l.data = w; wi_l.val = 1'b1; end
        for (int k = 0; k < 200; k++) begin
            acc = (sel == 0) ? wi_u.rdy : wi_l.rdy;
            @(negedge clk);
            if (acc) break;
        end
        wi_u.val = 1'b0;
        wi_l.val = 1'b0;
        if (!acc) check("push_timeout", acc, 1'b1);
    endtask

    task automatic wait_bytes(input int sel, input int n);
        for (int k = 0; k < 500; k++) begin
            if (qsize(sel) >= n) break;
            @(negedge clk);
        end
        check("wait_bytes", qsize(sel) >= n, 1'b1);
    endtask

    typedef struct {
        int          sel;
        logic [15:0] w;
        logic [39:0] exp;
    } vec_t;

    vec_t vec[8];

    initial begin
        vec[0] = '{0, 16'h0000, 40'h30_30_30_30_0A};
        vec[1] = '{0, 16'hFFFF, 40'h46_46_46_46_0A};
        vec[2] = '{0, 16'h8001, 40'h38_30_30_31_0A};
        vec[3] = '{0, 16'h9C5B, 40'h39_43_35_42_0A};
        vec[4] = '{0, 16'hDEAD, 40'h44_45_41_44_0A};
        vec[5] = '{1, 16'hBEEF, 40'h62_65_65_66_0A};
        vec[6] = '{1, 16'hA0C9, 40'h61_30_63_39_0A};
        vec[7] = '{1, 16'h7E3D, 40'h37_65_33_64_0A};

        rst = 1'b1; rdy_u = 1'b0; rdy_l = 1'b0;
        wi_u.val = 1'b0; wi_u.data = '0; wi_l.val = 1'b0; wi_l.data = '0;
        repeat (3) @(negedge clk);
        check("rst_val", tv_u, 1'b0);
        check("rst_byte", tb_u, 8'h00);
        check("rst_lvl", lv_u, 3'd0);
        check("rst_rdy", wi_u.rdy, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // First-byte latency and consecutive output for 1A2F.
        clr();
        rdy_u = 1'b1;
        wi_u.data = 16'h1A2F; wi_u.val = 1'b1;
        @(negedge clk);
        wi_u.val = 1'b0;
        check("lat_edge_n", tv_u, 1'b0);
        @(negedge clk);
        check("lat_val", tv_u, 1'b1);
        check("lat_byte", tb_u, 8'h31);
        wait_bytes(0, 5);
        check("v1A2F", pack(0, 0, 5), 40'h31_41_32_46_0A);
        check("v1A2F_consec", cyc_u[4] - cyc_u[0], 4);

        for (int i = 0; i < 8; i++) begin
            clr();
            rdy_u = 1'b1; rdy_l = 1'b1;
            push(vec[i].sel, vec[i].w);
            wait_bytes(vec[i].sel, 5);
            check($sformatf("vec%0d_bytes", i), pack(vec[i].sel, 0, 5), vec[i].exp);
            check($sformatf("vec%0d_consec", i),
                  (vec[i].sel == 0) ? (cyc_u[4] - cyc_u[0]) : (cyc_l[4] - cyc_l[0]), 4);
        end

        // Backpressure: fill shift register plus four FIFO slots, then release.
        clr();
        rdy_u = 1'b0;
        for (int i = 0; i < 5; i++) push(0, 16'(16'h1111 * (i + 1)));
        check("bp_lvl", lv_u, 3'd4);
        check("bp_rdy", wi_u.rdy, 1'b0);
        check("bp_val", tv_u, 1'b1);
        check("bp_byte", tb_u, 8'h31);
        wi_u.data = 16'h6666; wi_u.val = 1'b1;
        repeat (2) @(negedge clk);
        wi_u.val = 1'b0;
        check("full_lvl", lv_u, 3'd4);
        check("full_rdy", wi_u.rdy, 1'b0);
        rdy_u = 1'b1;
        wait_bytes(0, 25);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_w%0d", i), pack(0, 5 * i, 5), exp_word(16'(16'h1111 * (i + 1)), 1'b1));
        end
        check("bp_rate", cyc_u[24] - cyc_u[0], 24);
        repeat (10) @(negedge clk);
        check("bp_count", got_u.size(), 25);

        // Random ready toggling.
        clr();
        rdy_u = 1'b0;
        push(0, 16'h0000); push(0, 16'hFFFF); push(0, 16'h8001);
        for (int k = 0; k < 600; k++) begin
            if (got_u.size() >= 15) break;
            rdy_u = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rdy_u = 1'b1;
        wait_bytes(0, 15);
        check("rand_stream", pack(0, 0, 15), 120'h30303030_0A_46464646_0A_38303031_0A);

        // Push on the same edge as a pop with level 2.
        clr();
        rdy_u = 1'b0;
        push(0, 16'hC0DE); push(0, 16'h1357); push(0, 16'h2468);
        check("sim_lvl_pre", lv_u, 3'd2);
        rdy_u = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (tv_u && tb_u == 8'h0A) break;
            @(negedge clk);
        end
        check("sim_nl_seen", tb_u, 8'h0A);
        wi_u.data = 16'h9ABC; wi_u.val = 1'b1;
        @(negedge clk);
        wi_u.val = 1'b0;
        check("sim_lvl", lv_u, 3'd2);
        wait_bytes(0, 20);
        check("sim_w0", pack(0, 0, 5), 40'h43_30_44_45_0A);
        check("sim_w1", pack(0, 5, 5), 40'h31_33_35_37_0A);
        check("sim_w2", pack(0, 10, 5), 40'h32_34_36_38_0A);
        check("sim_w3", pack(0, 15, 5), 40'h39_41_42_43_0A);

        // Reset in the middle of a word with two words queued.
        repeat (5) @(negedge clk);
        clr();
        rdy_u = 1'b0;
        push(0, 16'h1234); push(0, 16'hAAAA); push(0, 16'hBBBB);
        check("mid_lvl", lv_u, 3'd2);
        rdy_u = 1'b1;
        repeat (2) @(negedge clk);
        rdy_u = 1'b0;
        check("mid_two", pack(0, 0, 2), 16'h31_32);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_val", tv_u, 1'b0);
        check("mid_rst_lvl", lv_u, 3'd0);
        rst = 1'b0;
        rdy_u = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_silent", got_u.size(), 2);
        push(0, 16'h00FF);
        wait_bytes(0, 7);
        repeat (10) @(negedge clk);
        check("mid_after", pack(0, 0, 7), 56'h31_32_30_30_46_46_0A);
        check("mid_count", got_u.size(), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/core_stdout_fmt.md
CORE_STDOUT_FMT -- requirements
Module: core_stdout_fmt

Interface
- REQ-001 SHALL have parameter DEPTH, default 4: word FIFO depth; power of two, 2..16.
- REQ-002 SHALL have parameter UPPER, default 1: 1 = hex letters 'A'-'F', 0 = 'a'-'f'.
- REQ-003 SHALL have port clk_i, input, 1: single clock; all state on rising edge.
- REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
- REQ-005 SHALL have port word_intf, stdio.in modport: data[15:0] and val in, rdy out; consumes the core's stdout word stream.
- REQ-006 SHALL have port tx_val_o, output, 1: byte valid.
- REQ-007 SHALL have port tx_byte_o, output, 8: ASCII byte.
- REQ-008 SHALL have port tx_rdy_i, input, 1: downstream byte ready.
- REQ-009 SHALL have port level_o, output, $clog2(DEPTH)+1: current FIFO occupancy.

Function
- REQ-010 Word accept SHALL occur on a clock edge where word_intf.val && word_intf.rdy; the word is written at the FIFO tail.
- REQ-011 word_intf.rdy SHALL equal !full, depending only on registered state; a pop in the same cycle SHALL NOT enable a push when full.
- REQ-012 Byte transfer SHALL occur on an edge where tx_val_o && tx_rdy_i.
- REQ-013 tx_val_o and tx_byte_o SHALL be registered and held stable until transferred.
- REQ-014 Formatter FSM SHALL have states IDLE, DIGIT, NL.
- REQ-015 IDLE: if FIFO non-empty, pop head into a 16-bit shift register, clear the digit counter, go to DIGIT, assert tx_val_o with digit of bits [15:12].
- REQ-016 DIGIT: on each transfer, shift left by 4 and increment the counter. After transfer of digit 3, present 0x0A and go to NL.
- REQ-017 NL: on transfer of 0x0A, go to IDLE. If FIFO is non-empty, pop and present the next word's first digit in the same edge, giving no bubble between words.
- REQ-018 Every word SHALL produce exactly five bytes: four hex digits MSB-first, then 0x0A.
- REQ-019 Nibble encoding: 0-9 -> 0x30-0x39; 10-15 -> 0x41-0x46 if UPPER=1, else 0x61-0x66.
- REQ-020 Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE SHALL have tx_val_o high in the cycle after edge N+1.
- REQ-021 Simultaneous push and pop with FIFO not full SHALL keep level_o unchanged.
- REQ-022 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by an extra pointer bit or a counter.
- REQ-023 tx_rdy_i held low SHALL stall the FSM indefinitely with no byte lost or duplicated; the FIFO still accepts words until full.
- REQ-024 Sustained throughput SHALL be one word per five byte transfers, with tx_rdy_i held high.

Reset
- REQ-025 While rst_i is high at an edge, the block SHALL clear pointers and level_o to 0, set the FSM to IDLE, drive tx_val_o 0 and tx_byte_o 0x00, and drive word_intf.rdy 1 in the cycle after.
- REQ-026 Reset mid-word SHALL discard the partial word and all buffered words; no byte SHALL be emitted after reset until a new word is accepted.

Structure
- REQ-027 Shared package core_pkg SHALL hold ASCII_NL (8'h0A), ASCII_0 (8'h30), ASCII_UA (8'h41), ASCII_LA (8'h61) and the fmt_state_e enum.
- REQ-028 FIFO storage SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/level); the FSM and encoder SHALL stay in core_stdout_fmt.

Verification
- REQ-029 Push 16'h1A2F with tx_rdy_i=1 -> bytes 0x31,0x41,0x32,0x46,0x0A on consecutive cycles, first byte two cycles after accept.
- REQ-030 UPPER=0, push 16'hBEEF -> bytes 0x62,0x65,0x65,0x66,0x0A.
- REQ-031 tx_rdy_i=0, push 5 words with DEPTH=4 -> word_intf.rdy drops after 4 FIFO words plus 1 in the shift register; level_o=4. Release -> all 25 bytes in order, none lost.
- REQ-032 Random tx_rdy_i toggling on 16'h0000, 16'hFFFF, 16'h8001 -> byte stream exactly "0000\nFFFF\n8001\n"; tx_byte_o stable whenever tx_val_o=1 && tx_rdy_i=0.
- REQ-033 Assert rst_i after the second digit of 16'h1234 with 2 words queued -> next cycle tx_val_o=0, level_o=0; a later push of 16'h00FF yields "00FF\n" only.
- REQ-034 Push on the same edge as a pop with level_o=2 -> level_o stays 2; push attempted when full -> ignored, rdy low.
